// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the CSA-based streaming accumulator.
package csa_acc_pkg;

  localparam int DATA_W = 32;

  // Value the running sum pins to once a carry-out is seen in saturating builds.
  localparam logic [DATA_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

  // ACC: taking operand beats. HOLD: presenting a finished frame result.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/csa_accumulator_csa.sv
// 32-bit carry-select adder: 4-bit blocks each precompute the sum for
// carry-in 0 and 1, and the ripple of block carries only drives the selects.
module csa_accumulator_csa
  import csa_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  localparam int BLK  = 4;
  localparam int NBLK = DATA_W / BLK;

  logic [NBLK:0] blk_c;

  assign blk_c[0] = cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;

    // Both candidate block sums are formed in parallel with the carry chain.
    assign s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign s1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + (BLK+1)'(1);

    assign sum[g*BLK +: BLK] = blk_c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign blk_c[g+1]        = blk_c[g] ? s1[BLK]     : s0[BLK];
  end

  assign cout = blk_c[NBLK];

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator around the carry-select adder.
// Sums a frame of operands, counts adder carry-outs and operands, and presents
// the totals on an output handshake.
// Optional build macro: CSA_ACC_SATURATE_EN -- once any carry-out occurs in a
// frame the running sum pins to all-ones instead of wrapping.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends combinationally on ready, and a producer holding
// valid keeps its payload stable until the transfer.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sum,
  output logic [COUNT_W-1:0] out_carries,
  output logic [COUNT_W-1:0] out_count,
  output state_t             dbg_state
);

  state_t              state;
  state_t              state_nxt;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   acc_nxt;
  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic [COUNT_W-1:0]  carries;
  logic [COUNT_W-1:0]  count;
  logic                accept;
  logic                release_res;

  // in_ready_q is only ever 1 while in ACC, so it alone qualifies a beat.
  assign accept      = in_valid & in_ready_q;
  assign release_res = out_valid_q & out_ready;

  csa_accumulator_csa u_csa (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef CSA_ACC_SATURATE_EN
  // Once saturated, acc is all-ones, so any nonzero operand carries out again
  // and a zero operand leaves it unchanged: the pin holds for the whole frame.
  assign acc_nxt = add_cout ? SAT_VAL : add_sum;
`else
  assign acc_nxt = add_sum;
`endif

  // Next-state logic: close the frame on an accepted last beat, reopen on release.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // State register plus registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ACC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == ACC);
      out_valid_q <= (state_nxt == HOLD);
    end
  end

  // Running sum and saturating counters; cleared when the result is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      carries <= '0;
      count   <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      if (add_cout && (carries != '1)) carries <= carries + COUNT_W'(1);
      if (count != '1)                 count   <= count + COUNT_W'(1);
    end else if (release_res) begin
      acc     <= '0;
      carries <= '0;
      count   <= '0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = acc;
  assign out_carries = carries;
  assign out_count   = count;
  assign dbg_state   = state;

endmodule
